// File: rtl/unified_mem_arbiter.sv
// Two-requester (fetch / data) arbiter for one single-port unified memory with fixed wait states.
// Define ARB_ROUND_ROBIN_EN to alternate grants under contention; the default build gives DM fixed priority.
module unified_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ack,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_cnt;
  logic                r_gnt_dm;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [BE_W-1:0]     r_be;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_dm_rdata;
  logic                w_grant_dm;
  logic                w_any_req;
  logic                w_last_beat;

  assign w_any_req   = if_req | dm_req;
  assign w_last_beat = (r_state == S_ACCESS) && (r_cnt == 4'd0);

`ifdef ARB_ROUND_ROBIN_EN
  // r_last_dm = 1 when DM held the most recent grant; under contention the other side wins.
  logic r_last_dm;

  assign w_grant_dm = dm_req & (~if_req | ~r_last_dm);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_dm <= 1'b0;
    end else if (r_state == S_IDLE && w_any_req) begin
      r_last_dm <= w_grant_dm;
    end
  end
`else
  assign w_grant_dm = dm_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_be      = '0;
    if_ack      = 1'b0;
    dm_ack      = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_any_req) begin
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_en = 1'b1;
        mem_we = r_gnt_dm & r_we;
        mem_be = r_be;
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if_ack      = ~r_gnt_dm;
        dm_ack      = r_gnt_dm;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Request latch and wait-state counter; addr/wdata stay put between accesses so the bus holds its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= 4'd0;
      r_gnt_dm <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
    end else if (r_state == S_IDLE && w_any_req) begin
      r_cnt    <= CNT_LOAD;
      r_gnt_dm <= w_grant_dm;
      if (w_grant_dm) begin
        r_we    <= dm_we;
        r_addr  <= dm_addr;
        r_wdata <= dm_wdata;
        r_be    <= dm_be;
      end else begin
        r_we    <= 1'b0;
        r_addr  <= if_addr;
        r_be    <= '1;
      end
    end else if (r_state == S_ACCESS && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Read data is captured on the final wait-state cycle; DM writes leave dm_rdata alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else if (w_last_beat) begin
      if (!r_gnt_dm) begin
        r_if_rdata <= mem_rdata;
      end else if (!r_we) begin
        r_dm_rdata <= mem_rdata;
      end
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;

endmodule
